id_stage: RTL and testbench

Instruction-decode stage that sits directly downstream of the IF/ID register and consumes its instruction and PC. It holds the 32x32 register file, decodes the RV32I subset into control signals, generates immediates, detects load-use hazards (stalling PC and IF/ID), and registers everything into the ID/EX pipeline register for the execute stage. A flush input from EX kills the instruction in decode on a taken branch.

---
 rtl/id_stage.sv | 233 +++++++++++++++++++++++
 tb/tb_id_stage.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// Instruction-decode stage: register file, RV32I subset decoder, immediate
// generation, load-use hazard detection and the ID/EX pipeline register.
module id_stage #(
   parameter int ADDR_W = 8,
   parameter int XLEN   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       instruction_in,
   input  logic [ADDR_W-1:0] pc_in,
   input  logic              valid_in,
   input  logic              flush,
   input  logic              wb_en,
   input  logic [4:0]        wb_rd,
   input  logic [XLEN-1:0]   wb_data,
   output logic              stall,
   output logic              ex_valid,
   output logic [ADDR_W-1:0] ex_pc,
   output logic [XLEN-1:0]   ex_rs1_data,
   output logic [XLEN-1:0]   ex_rs2_data,
   output logic [XLEN-1:0]   ex_imm,
   output logic [4:0]        ex_rs1,
   output logic [4:0]        ex_rs2,
   output logic [4:0]        ex_rd,
   output logic [2:0]        ex_funct3,
   output logic              ex_funct7b5,
   output logic [1:0]        ex_alu_op,
   output logic              ex_reg_write,
   output logic              ex_mem_read,
   output logic              ex_mem_write,
   output logic              ex_mem_to_reg,
   output logic              ex_alu_src,
   output logic              ex_branch
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   // Instruction fields
   logic [6:0] opcode_s;
   logic [4:0] rs1_s, rs2_s, rd_s;
   assign opcode_s = instruction_in[6:0];
   assign rd_s     = instruction_in[11:7];
   assign rs1_s    = instruction_in[19:15];
   assign rs2_s    = instruction_in[24:20];

   // Decoded controls
   logic            supported_s, rs2_used_s;
   logic            reg_write_s, mem_read_s, mem_write_s, mem_to_reg_s, alu_src_s, branch_s;
   logic [1:0]      alu_op_s;
   logic [XLEN-1:0] imm_s;
   logic [XLEN-1:0] rs1_data_s, rs2_data_s;
   logic            stall_s;

   logic [XLEN-1:0] regs_r [32];

   // ID/EX pipeline registers
   logic              ex_valid_r;
   logic [ADDR_W-1:0] ex_pc_r;
   logic [XLEN-1:0]   ex_rs1_data_r, ex_rs2_data_r, ex_imm_r;
   logic [4:0]        ex_rs1_r, ex_rs2_r, ex_rd_r;
   logic [2:0]        ex_funct3_r;
   logic              ex_funct7b5_r;
   logic [1:0]        ex_alu_op_r;
   logic              ex_reg_write_r, ex_mem_read_r, ex_mem_write_r;
   logic              ex_mem_to_reg_r, ex_alu_src_r, ex_branch_r;

   // Register file: cleared on reset, written from writeback; x0 never written
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            regs_r[i] <= {XLEN{1'b0}};
         end
      end else if (wb_en && (wb_rd != 5'd0)) begin
         regs_r[wb_rd] <= wb_data;
      end
   end

   // Read port rs1: x0 reads zero, same-cycle writeback is forwarded (write-first)
   always_comb begin
      if (rs1_s == 5'd0) begin
         rs1_data_s = {XLEN{1'b0}};
      end else if (wb_en && (wb_rd == rs1_s)) begin
         rs1_data_s = wb_data;
      end else begin
         rs1_data_s = regs_r[rs1_s];
      end
   end

   // Read port rs2: same forwarding rules as rs1
   always_comb begin
      if (rs2_s == 5'd0) begin
         rs2_data_s = {XLEN{1'b0}};
      end else if (wb_en && (wb_rd == rs2_s)) begin
         rs2_data_s = wb_data;
      end else begin
         rs2_data_s = regs_r[rs2_s];
      end
   end

   // Opcode decode into control signals and the sign-extended immediate
   always_comb begin
      supported_s  = 1'b0;
      rs2_used_s   = 1'b0;
      reg_write_s  = 1'b0;
      mem_read_s   = 1'b0;
      mem_write_s  = 1'b0;
      mem_to_reg_s = 1'b0;
      alu_src_s    = 1'b0;
      branch_s     = 1'b0;
      alu_op_s     = 2'b00;
      imm_s        = {XLEN{1'b0}};
      case (opcode_s)
         OP_R: begin
            supported_s = 1'b1;
            rs2_used_s  = 1'b1;
            reg_write_s = 1'b1;
            alu_op_s    = 2'b10;
         end
         OP_I: begin
            supported_s = 1'b1;
            reg_write_s = 1'b1;
            alu_src_s   = 1'b1;
            alu_op_s    = 2'b11;
            imm_s       = {{(XLEN-12){instruction_in[31]}}, instruction_in[31:20]};
         end
         OP_LOAD: begin
            supported_s  = 1'b1;
            reg_write_s  = 1'b1;
            mem_read_s   = 1'b1;
            mem_to_reg_s = 1'b1;
            alu_src_s    = 1'b1;
            alu_op_s     = 2'b00;
            imm_s        = {{(XLEN-12){instruction_in[31]}}, instruction_in[31:20]};
         end
         OP_STORE: begin
            supported_s = 1'b1;
            rs2_used_s  = 1'b1;
            mem_write_s = 1'b1;
            alu_src_s   = 1'b1;
            alu_op_s    = 2'b00;
            imm_s       = {{(XLEN-12){instruction_in[31]}}, instruction_in[31:25], instruction_in[11:7]};
         end
         OP_BRANCH: begin
            supported_s = 1'b1;
            rs2_used_s  = 1'b1;
            branch_s    = 1'b1;
            alu_op_s    = 2'b01;
            imm_s       = {{(XLEN-13){instruction_in[31]}}, instruction_in[31], instruction_in[7],
                           instruction_in[30:25], instruction_in[11:8], 1'b0};
         end
         default: begin
            supported_s = 1'b0;
         end
      endcase
   end

   // Load-use hazard: a load in EX whose rd feeds this instruction; flush wins
   always_comb begin
      if (rst || flush || !valid_in) begin
         stall_s = 1'b0;
      end else if (ex_valid_r && ex_mem_read_r && (ex_rd_r != 5'd0) &&
                   ((ex_rd_r == rs1_s) || (rs2_used_s && (ex_rd_r == rs2_s)))) begin
         stall_s = 1'b1;
      end else begin
         stall_s = 1'b0;
      end
   end

   // ID/EX register: load the decoded instruction or insert a zeroed bubble
   always_ff @(posedge clk) begin
      if (rst || flush || !valid_in || stall_s || !supported_s) begin
         ex_valid_r      <= 1'b0;
         ex_pc_r         <= {ADDR_W{1'b0}};
         ex_rs1_data_r   <= {XLEN{1'b0}};
         ex_rs2_data_r   <= {XLEN{1'b0}};
         ex_imm_r        <= {XLEN{1'b0}};
         ex_rs1_r        <= 5'd0;
         ex_rs2_r        <= 5'd0;
         ex_rd_r         <= 5'd0;
         ex_funct3_r     <= 3'd0;
         ex_funct7b5_r   <= 1'b0;
         ex_alu_op_r     <= 2'b00;
         ex_reg_write_r  <= 1'b0;
         ex_mem_read_r   <= 1'b0;
         ex_mem_write_r  <= 1'b0;
         ex_mem_to_reg_r <= 1'b0;
         ex_alu_src_r    <= 1'b0;
         ex_branch_r     <= 1'b0;
      end else begin
         ex_valid_r      <= 1'b1;
         ex_pc_r         <= pc_in;
         ex_rs1_data_r   <= rs1_data_s;
         ex_rs2_data_r   <= rs2_data_s;
         ex_imm_r        <= imm_s;
         ex_rs1_r        <= rs1_s;
         ex_rs2_r        <= rs2_s;
         ex_rd_r         <= rd_s;
         ex_funct3_r     <= instruction_in[14:12];
         ex_funct7b5_r   <= instruction_in[30];
         ex_alu_op_r     <= alu_op_s;
         ex_reg_write_r  <= reg_write_s;
         ex_mem_read_r   <= mem_read_s;
         ex_mem_write_r  <= mem_write_s;
         ex_mem_to_reg_r <= mem_to_reg_s;
         ex_alu_src_r    <= alu_src_s;
         ex_branch_r     <= branch_s;
      end
   end

   assign stall         = stall_s;
   assign ex_valid      = ex_valid_r;
   assign ex_pc         = ex_pc_r;
   assign ex_rs1_data   = ex_rs1_data_r;
   assign ex_rs2_data   = ex_rs2_data_r;
   assign ex_imm        = ex_imm_r;
   assign ex_rs1        = ex_rs1_r;
   assign ex_rs2        = ex_rs2_r;
   assign ex_rd         = ex_rd_r;
   assign ex_funct3     = ex_funct3_r;
   assign ex_funct7b5   = ex_funct7b5_r;
   assign ex_alu_op     = ex_alu_op_r;
   assign ex_reg_write  = ex_reg_write_r;
   assign ex_mem_read   = ex_mem_read_r;
   assign ex_mem_write  = ex_mem_write_r;
   assign ex_mem_to_reg = ex_mem_to_reg_r;
   assign ex_alu_src    = ex_alu_src_r;
   assign ex_branch     = ex_branch_r;

endmodule

// File: tb/tb_id_stage.sv
// Testbench for id_stage: directed vector table, then randomized traffic
// checked against a behavioural model of decode, register file and hazards.
module tb_id_stage;
   localparam int ADDR_W = 8;
   localparam int XLEN   = 32;

   localparam logic [6:0] OP_R = 7'b0110011;
   localparam logic [6:0] OP_I = 7'b0010011;
   localparam logic [6:0] OP_L = 7'b0000011;
   localparam logic [6:0] OP_S = 7'b0100011;
   localparam logic [6:0] OP_B = 7'b1100011;

   // {alu_op, reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch}
   localparam logic [7:0] C_R = 8'b10_100000;
   localparam logic [7:0] C_I = 8'b11_100010;
   localparam logic [7:0] C_L = 8'b00_110110;
   localparam logic [7:0] C_S = 8'b00_001010;
   localparam logic [7:0] C_B = 8'b01_000001;
   localparam logic [7:0] C_0 = 8'b00_000000;

   logic clk = 1'b0;
   logic rst, valid_in, flush, wb_en;
   logic [31:0] instruction_in;
   logic [ADDR_W-1:0] pc_in;
   logic [4:0] wb_rd;
   logic [XLEN-1:0] wb_data;
   logic stall, ex_valid;
   logic [ADDR_W-1:0] ex_pc;
   logic [XLEN-1:0] ex_rs1_data, ex_rs2_data, ex_imm;
   logic [4:0] ex_rs1, ex_rs2, ex_rd;
   logic [2:0] ex_funct3;
   logic ex_funct7b5;
   logic [1:0] ex_alu_op;
   logic ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_branch;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   id_stage #(.ADDR_W(ADDR_W), .XLEN(XLEN)) dut (
      .clk(clk), .rst(rst), .instruction_in(instruction_in), .pc_in(pc_in),
      .valid_in(valid_in), .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
      .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
      .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
      .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5), .ex_alu_op(ex_alu_op),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_src(ex_alu_src), .ex_branch(ex_branch)
   );

   typedef struct packed {
      logic        valid;
      logic [7:0]  pc;
      logic [31:0] d1;
      logic [31:0] d2;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [2:0]  funct3;
      logic        f7b5;
      logic [7:0]  ctrl;
   } ex_t;

   typedef struct {
      logic        rst;
      logic [31:0] instr;
      logic        valid;
      logic        flush;
      logic        wb_en;
      logic [4:0]  wb_rd;
      logic [31:0] wb_data;
      logic        e_stall;
      logic        e_valid;
      logic [4:0]  e_rs1;
      logic [4:0]  e_rd;
      logic [31:0] e_d1;
      logic [31:0] e_d2;
      logic [31:0] e_imm;
      logic [7:0]  e_ctrl;
   } vec_t;

   vec_t tbl[$];
   ex_t dut_ex;
   logic [7:0] dut_ctrl;
   logic [31:0] m_regs [32];
   ex_t m_ex;

   assign dut_ctrl = {ex_alu_op, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_branch};
   assign dut_ex = {ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
                    ex_funct3, ex_funct7b5, dut_ctrl};

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic row(input logic r, input logic [31:0] ins, input logic v, input logic f,
                      input logic we, input logic [4:0] wr, input logic [31:0] wd, input logic es,
                      input logic ev, input logic [4:0] ers1, input logic [4:0] erd,
                      input logic [31:0] ed1, input logic [31:0] ed2, input logic [31:0] eimm,
                      input logic [7:0] ectrl);
      vec_t t;
      t.rst = r; t.instr = ins; t.valid = v; t.flush = f; t.wb_en = we; t.wb_rd = wr; t.wb_data = wd;
      t.e_stall = es; t.e_valid = ev; t.e_rs1 = ers1; t.e_rd = erd; t.e_d1 = ed1; t.e_d2 = ed2;
      t.e_imm = eimm; t.e_ctrl = ectrl;
      tbl.push_back(t);
   endtask

   // bubble row: every ID/EX field expected zero
   task automatic bub(input logic r, input logic [31:0] ins, input logic v, input logic f,
                      input logic we, input logic [4:0] wr, input logic [31:0] wd, input logic es);
      row(r, ins, v, f, we, wr, wd, es, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, C_0);
   endtask

   task automatic drive(input logic r, input logic [31:0] ins, input logic [7:0] pc, input logic v,
                        input logic f, input logic we, input logic [4:0] wr, input logic [31:0] wd);
      rst = r; instruction_in = ins; pc_in = pc; valid_in = v; flush = f;
      wb_en = we; wb_rd = wr; wb_data = wd;
   endtask

   // model register read with write-first forwarding of the current writeback
   function automatic logic [31:0] model_read(input logic [4:0] r);
      if (r == 5'd0) return 32'd0;
      if (wb_en && (wb_rd == r)) return wb_data;
      return m_regs[r];
   endfunction

   // what the execute stage should receive for a supported, issuing instruction
   function automatic ex_t model_decode(input logic [31:0] ins, input logic [7:0] pc,
                                        input logic [31:0] d1, input logic [31:0] d2);
      ex_t e;
      logic signed [11:0] i12;
      logic signed [12:0] b13;
      e = '0;
      e.valid = 1'b1; e.pc = pc; e.d1 = d1; e.d2 = d2;
      e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
      e.funct3 = ins[14:12]; e.f7b5 = ins[30];
      case (ins[6:0])
         OP_R: e.ctrl = C_R;
         OP_I: begin e.ctrl = C_I; i12 = ins[31:20]; e.imm = 32'(i12); end
         OP_L: begin e.ctrl = C_L; i12 = ins[31:20]; e.imm = 32'(i12); end
         OP_S: begin e.ctrl = C_S; i12 = {ins[31:25], ins[11:7]}; e.imm = 32'(i12); end
         OP_B: begin
            e.ctrl = C_B;
            b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            e.imm = 32'(b13);
         end
         default: e = '0;
      endcase
      return e;
   endfunction

   initial begin
      logic [7:0] pc;
      logic [31:0] ins;
      logic v, f, r, hold, e_stall, use2, sup;
      logic [6:0] op;
      ex_t nxt;

      // ---------------- directed vector table ----------------
      bub(1'b1, 32'h002081B3, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);               // reset
      bub(1'b1, 32'h002081B3, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);               // reset
      row(1'b0, 32'h002081B3, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd1, 5'd3, 32'd0, 32'd0, 32'd0, C_R);
      bub(1'b0, 32'h002081B3, 1'b0, 1'b0, 1'b1, 5'd1, 32'd5, 1'b0);               // wb x1=5
      bub(1'b0, 32'h002081B3, 1'b0, 1'b0, 1'b1, 5'd2, 32'd7, 1'b0);               // wb x2=7
      row(1'b0, 32'h002081B3, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd1, 5'd3, 32'd5, 32'd7, 32'd0, C_R);
      row(1'b0, 32'h002081B3, 1'b1, 1'b0, 1'b1, 5'd1, 32'hAAAA5555, 1'b0, 1'b1, 5'd1, 5'd3, 32'hAAAA5555, 32'd7, 32'd0, C_R);
      bub(1'b0, 32'h0000007F, 1'b0, 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0);        // wb x0 ignored
      row(1'b0, 32'hFFF00093, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd0, 5'd1, 32'd0, 32'd0, 32'hFFFFFFFF, C_I);
      row(1'b0, 32'h0000A283, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd1, 5'd5, 32'hAAAA5555, 32'd0, 32'd0, C_L);
      bub(1'b0, 32'h00228333, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);               // load-use stall
      row(1'b0, 32'h00228333, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd5, 5'd6, 32'd0, 32'd7, 32'd0, C_R);
      row(1'b0, 32'h0000A283, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd1, 5'd5, 32'hAAAA5555, 32'd0, 32'd0, C_L);
      bub(1'b0, 32'h00228333, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);               // flush beats stall
      row(1'b0, 32'h00228333, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd5, 5'd6, 32'd0, 32'd7, 32'd0, C_R);
      row(1'b0, 32'hFE20AE23, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd1, 5'd28, 32'hAAAA5555, 32'd7, 32'hFFFFFFFC, C_S);
      row(1'b0, 32'hFE208CE3, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd1, 5'd25, 32'hAAAA5555, 32'd7, 32'hFFFFFFF8, C_B);
      bub(1'b0, 32'h0000007F, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);               // illegal opcode
      row(1'b0, 32'h0000A283, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd1, 5'd5, 32'hAAAA5555, 32'd0, 32'd0, C_L);
      row(1'b0, 32'h00012303, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd2, 5'd6, 32'd7, 32'd0, 32'd0, C_L);
      bub(1'b0, 32'h00032383, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);               // load->load dependent
      row(1'b0, 32'h00032383, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd6, 5'd7, 32'd0, 32'd0, 32'd0, C_L);
      bub(1'b0, 32'h000380B3, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);               // invalid: no stall

      for (int i = 0; i < tbl.size(); i++) begin
         pc = 8'(i * 4);
         drive(tbl[i].rst, tbl[i].instr, pc, tbl[i].valid, tbl[i].flush, tbl[i].wb_en, tbl[i].wb_rd, tbl[i].wb_data);
         #2;
         check($sformatf("row%0d_stall", i), 160'(stall), 160'(tbl[i].e_stall));
         @(posedge clk);
         #1;
         check($sformatf("row%0d_ex", i),
               160'({ex_valid, ex_pc, ex_rs1, ex_rd, ex_rs1_data, ex_rs2_data, ex_imm, dut_ctrl}),
               160'({tbl[i].e_valid, (tbl[i].e_valid ? pc : 8'd0), tbl[i].e_rs1, tbl[i].e_rd,
                     tbl[i].e_d1, tbl[i].e_d2, tbl[i].e_imm, tbl[i].e_ctrl}));
      end

      // ---------------- randomized traffic against the model ----------------
      for (int k = 0; k < 32; k++) m_regs[k] = 32'd0;
      m_ex = '0;
      hold = 1'b0;
      ins = 32'd0; pc = 8'd0; v = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if (!hold) begin
            ins = $urandom;
            case ($urandom_range(0, 5))
               0: op = OP_R;
               1: op = OP_I;
               2: op = OP_L;
               3: op = OP_S;
               4: op = OP_B;
               default: op = 7'h37;
            endcase
            ins[6:0]   = op;
            ins[11:7]  = 5'($urandom_range(0, 7));
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
            pc = 8'($urandom);
            v  = ($urandom_range(0, 9) != 0);
         end
         r = (c < 2) || ($urandom_range(0, 299) == 0);
         f = ($urandom_range(0, 7) == 0);
         drive(r, ins, pc, v, f, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
         #2;
         op   = ins[6:0];
         use2 = (op == OP_R) || (op == OP_S) || (op == OP_B);
         sup  = use2 || (op == OP_I) || (op == OP_L);
         e_stall = !r && v && !f && m_ex.valid && (m_ex.ctrl == C_L) && (m_ex.rd != 5'd0) &&
                   ((m_ex.rd == ins[19:15]) || (use2 && (m_ex.rd == ins[24:20])));
         check($sformatf("rand%0d_stall", c), 160'(stall), 160'(e_stall));
         nxt = '0;
         if (!r && v && !f && !e_stall && sup) begin
            nxt = model_decode(ins, pc, model_read(ins[19:15]), model_read(ins[24:20]));
         end
         @(posedge clk);
         if (r) begin
            for (int k = 0; k < 32; k++) m_regs[k] = 32'd0;
         end else if (wb_en && (wb_rd != 5'd0)) begin
            m_regs[wb_rd] = wb_data;
         end
         m_ex = nxt;
         #1;
         check($sformatf("rand%0d_ex", c), 160'(dut_ex), 160'(m_ex));
         hold = e_stall;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
